// File: rtl/float_normalize.sv
// Post-add/subtract normalization: shifts the raw significand sum until the hidden bit is set,
// one shift per cycle, and hands normMant/normExp/R/S to the rounding stage over valid/ready.
module float_normalize #(
  parameter int unsigned N     = 24,
  parameter int unsigned EXP_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [N:0]       i_in_mant,
  input  logic             i_in_guard,
  input  logic             i_in_round,
  input  logic             i_in_sticky,
  input  logic [EXP_W-1:0] i_in_exp,
  input  logic             i_in_sign,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [N-1:0]     o_norm_mant,
  output logic [EXP_W-1:0] o_norm_exp,
  output logic             o_r,
  output logic             o_s,
  output logic             o_sign_out,
  output logic             o_zero_out,
  output logic             o_overflow
);

  localparam int unsigned      CNT_W     = $clog2(N + 3);
  localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_MAX   = '1;
  localparam logic [EXP_W-1:0] EXP_SAT   = EXP_MAX - EXP_ONE;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(N + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RSHIFT,
    S_LSHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [N:0]       r_mant;
  logic             r_g;
  logic             r_r;
  logic             r_s;
  logic [EXP_W-1:0] r_e;
  logic             r_sign;
  logic [CNT_W-1:0] r_cnt;

  logic             r_in_ready;
  logic             r_out_valid;
  logic [N-1:0]     r_norm_mant;
  logic [EXP_W-1:0] r_norm_exp;
  logic             r_out_r;
  logic             r_out_s;
  logic             r_sign_out;
  logic             r_zero_out;
  logic             r_overflow;

  // Input classification
  logic             w_in_zero;
  logic             w_in_direct;

  assign w_in_zero   = (i_in_mant == '0) && !i_in_guard && !i_in_round && !i_in_sticky;
  // Exponent already 0 means no room to shift left: deliver as a denormal.
  assign w_in_direct = i_in_mant[N-1] || (i_in_exp == '0);

  // Right-shift step (carry-out present)
  logic [N:0]       w_rs_mant;
  logic [EXP_W-1:0] w_rs_e;
  logic             w_rs_ovf;

  assign w_rs_mant = {1'b0, r_mant[N:1]};
  assign w_rs_e    = r_e + EXP_ONE;
  // Saturate rather than wrap if the exponent is already at or one below all-ones.
  assign w_rs_ovf  = (r_e == EXP_SAT) || (r_e == EXP_MAX);

  // Left-shift step
  logic [N:0]       w_ls_mant;
  logic [EXP_W-1:0] w_ls_e;
  logic [CNT_W-1:0] w_ls_cnt;
  logic             w_ls_exit;
  logic             w_ls_zero;

  assign w_ls_mant = {r_mant[N-1:0], r_g};
  assign w_ls_e    = r_e - EXP_ONE;
  assign w_ls_cnt  = r_cnt + CNT_ONE;
  assign w_ls_exit = w_ls_mant[N-1] || (w_ls_e == '0) || (w_ls_cnt == CNT_GUARD);
  // Guard exit with neither hidden bit nor exhausted exponent: nothing left to normalize.
  assign w_ls_zero = !w_ls_mant[N-1] && (w_ls_e != '0);

  // Control, datapath and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_mant      <= '0;
      r_g         <= 1'b0;
      r_r         <= 1'b0;
      r_s         <= 1'b0;
      r_e         <= '0;
      r_sign      <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_norm_mant <= '0;
      r_norm_exp  <= '0;
      r_out_r     <= 1'b0;
      r_out_s     <= 1'b0;
      r_sign_out  <= 1'b0;
      r_zero_out  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (i_in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_mant     <= i_in_mant;
            r_g        <= i_in_guard;
            r_r        <= i_in_round;
            r_s        <= i_in_sticky;
            r_e        <= i_in_exp;
            r_sign     <= i_in_sign;
            r_cnt      <= '0;
            if (w_in_zero) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_zero_out  <= 1'b1;
              r_norm_mant <= '0;
              r_norm_exp  <= '0;
              r_out_r     <= 1'b0;
              r_out_s     <= 1'b0;
              r_sign_out  <= i_in_sign;
            end else if (i_in_mant[N]) begin
              r_state <= S_RSHIFT;
            end else if (w_in_direct) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_norm_mant <= i_in_mant[N-1:0];
              r_norm_exp  <= i_in_exp;
              r_out_r     <= i_in_guard;
              r_out_s     <= i_in_round | i_in_sticky;
              r_sign_out  <= i_in_sign;
            end else begin
              r_state <= S_LSHIFT;
            end
          end
        end

        S_RSHIFT: begin
          r_mant      <= w_rs_mant;
          r_g         <= r_mant[0];
          r_r         <= r_g;
          r_s         <= r_r | r_s;
          r_e         <= w_rs_e;
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
          r_sign_out  <= r_sign;
          if (w_rs_ovf) begin
            r_overflow  <= 1'b1;
            r_norm_exp  <= EXP_MAX;
            r_norm_mant <= '0;
            r_out_r     <= 1'b0;
            r_out_s     <= 1'b0;
          end else begin
            r_norm_mant <= w_rs_mant[N-1:0];
            r_norm_exp  <= w_rs_e;
            r_out_r     <= r_mant[0];
            r_out_s     <= r_g | r_r | r_s;
          end
        end

        S_LSHIFT: begin
          r_mant <= w_ls_mant;
          r_g    <= r_r;
          r_r    <= 1'b0;
          r_e    <= w_ls_e;
          r_cnt  <= w_ls_cnt;
          if (w_ls_exit) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_sign_out  <= r_sign;
            if (w_ls_zero) begin
              r_zero_out  <= 1'b1;
              r_norm_mant <= '0;
              r_norm_exp  <= '0;
              r_out_r     <= 1'b0;
              r_out_s     <= 1'b0;
            end else begin
              r_norm_mant <= w_ls_mant[N-1:0];
              r_norm_exp  <= w_ls_e;
              r_out_r     <= r_r;
              r_out_s     <= r_s;
            end
          end
        end

        S_DONE: begin
          // Result held until consumed; release clears everything and reopens the input.
          if (i_out_ready) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_norm_mant <= '0;
            r_norm_exp  <= '0;
            r_out_r     <= 1'b0;
            r_out_s     <= 1'b0;
            r_sign_out  <= 1'b0;
            r_zero_out  <= 1'b0;
            r_overflow  <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_norm_mant = r_norm_mant;
  assign o_norm_exp  = r_norm_exp;
  assign o_r         = r_out_r;
  assign o_s         = r_out_s;
  assign o_sign_out  = r_sign_out;
  assign o_zero_out  = r_zero_out;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_float_normalize.sv
// Bench for float_normalize: directed and random sums against a leading-one based reference,
// with a queue scoreboard checking results, latency, hold stability and reset behaviour.
module tb_float_normalize;

  logic        clk;
  logic        rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [24:0] i_in_mant;
  logic        i_in_guard;
  logic        i_in_round;
  logic        i_in_sticky;
  logic [7:0]  i_in_exp;
  logic        i_in_sign;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [23:0] o_norm_mant;
  logic [7:0]  o_norm_exp;
  logic        o_r;
  logic        o_s;
  logic        o_sign_out;
  logic        o_zero_out;
  logic        o_overflow;

  float_normalize #(.N(24), .EXP_W(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_mant   (i_in_mant),
    .i_in_guard  (i_in_guard),
    .i_in_round  (i_in_round),
    .i_in_sticky (i_in_sticky),
    .i_in_exp    (i_in_exp),
    .i_in_sign   (i_in_sign),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_norm_mant (o_norm_mant),
    .o_norm_exp  (o_norm_exp),
    .o_r         (o_r),
    .o_s         (o_s),
    .o_sign_out  (o_sign_out),
    .o_zero_out  (o_zero_out),
    .o_overflow  (o_overflow)
  );

  typedef struct {
    logic [23:0] mant;
    logic [7:0]  exp;
    logic        r;
    logic        s;
    logic        sign;
    logic        zero;
    logic        ovf;
    int          vcyc;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          force_hold = 1'b0;
  logic [36:0] out_vec;

  assign out_vec = {o_norm_mant, o_norm_exp, o_r, o_s, o_sign_out, o_zero_out, o_overflow};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [36:0] expvec(input exp_t x);
    return {x.mant, x.exp, x.r, x.s, x.sign, x.zero, x.ovf};
  endfunction

  // Reference: locate the leading one and shift the {mant,g,r} window in one step.
  function automatic void model(input logic [24:0] m, input logic g, input logic r,
                                input logic s, input logic [7:0] e, input logic sg,
                                output exp_t x, output int lat);
    logic [25:0] w;
    int          p;
    int          k;
    x.mant = '0; x.exp = '0; x.r = 1'b0; x.s = 1'b0;
    x.sign = sg; x.zero = 1'b0; x.ovf = 1'b0; x.vcyc = 0;
    lat = 1;
    if (m == 25'd0 && !g && !r && !s) begin
      x.zero = 1'b1;
    end else if (m[24]) begin
      lat = 2;
      if (e >= 8'd254) begin
        x.ovf = 1'b1;
        x.exp = 8'hFF;
      end else begin
        x.mant = m[24:1];
        x.exp  = e + 8'd1;
        x.r    = m[0];
        x.s    = g | r | s;
      end
    end else if (m[23] || e == 8'd0) begin
      x.mant = m[23:0];
      x.exp  = e;
      x.r    = g;
      x.s    = r | s;
    end else begin
      w = {m[23:0], g, r};
      if (w == 26'd0) begin
        if (int'(e) <= 26) begin
          lat = 1 + int'(e);
          x.s = s;
        end else begin
          lat    = 27;
          x.zero = 1'b1;
        end
      end else begin
        p = 0;
        for (int i = 0; i < 26; i++) if (w[i]) p = i;
        k = 25 - p;
        if (k > int'(e)) k = int'(e);
        w      = w << k;
        x.mant = w[25:2];
        x.exp  = e - 8'(k);
        x.r    = w[1];
        x.s    = w[0] | s;
        lat    = 1 + k;
      end
    end
  endfunction

  // Called in the posedge+#1 phase; returns one cycle after the capture edge.
  task automatic send(input logic [24:0] m, input logic g, input logic r, input logic s,
                      input logic [7:0] e, input logic sg);
    exp_t x;
    int   lat;
    int   t;
    model(m, g, r, s, e, sg, x, lat);
    t = 0;
    while (!o_in_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!o_in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck low after %0d cycles", t);
      return;
    end
    i_in_mant   = m;
    i_in_guard  = g;
    i_in_round  = r;
    i_in_sticky = s;
    i_in_exp    = e;
    i_in_sign   = sg;
    i_in_valid  = 1'b1;
    x.vcyc      = cyc + lat;
    q.push_back(x);
    @(posedge clk); #1;
    i_in_valid  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || o_out_valid) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding", q.size());
    end
  endtask

  // Downstream ready: random back-pressure, or held low on request
  initial begin
    i_out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      i_out_ready = force_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard
  initial begin
    bit          pv;
    logic [36:0] ps;
    exp_t        x;
    pv = 1'b0;
    ps = '0;
    forever begin
      @(negedge clk);
      if (!o_out_valid) begin
        check("idle_outputs_zero", 64'(out_vec), 64'd0);
        pv = 1'b0;
      end else begin
        check("in_ready_low_while_valid", 64'(o_in_ready), 64'd0);
        if (!pv) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %h expected nothing", out_vec);
          end else begin
            check("latency", 64'(cyc), 64'(q[0].vcyc));
          end
        end else begin
          check("held_stable", 64'(out_vec), 64'(ps));
        end
        if (i_out_ready && q.size() != 0) begin
          x = q.pop_front();
          check("result", 64'(out_vec), 64'(expvec(x)));
        end
        pv = !i_out_ready;
        ps = out_vec;
      end
    end
  end

  initial begin
    logic [24:0] m;
    logic        g;
    logic        r;
    logic        s;
    logic [7:0]  e;
    int          mode;
    int          lz;
    int          t;

    rst_n       = 1'b0;
    i_in_valid  = 1'b0;
    i_in_mant   = '0;
    i_in_guard  = 1'b0;
    i_in_round  = 1'b0;
    i_in_sticky = 1'b0;
    i_in_exp    = '0;
    i_in_sign   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 64'(o_in_ready), 64'd0);
    check("reset_out_valid", 64'(o_out_valid), 64'd0);
    check("reset_outputs", 64'(out_vec), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", 64'(o_in_ready), 64'd1);

    send(25'h0800000, 1'b0, 1'b0, 1'b0, 8'd127, 1'b0);
    send(25'h1800001, 1'b0, 1'b1, 1'b0, 8'd127, 1'b0);
    send(25'h0000100, 1'b0, 1'b0, 1'b0, 8'd100, 1'b0);
    send(25'h0000000, 1'b0, 1'b0, 1'b0, 8'd90,  1'b1);
    send(25'h1000000, 1'b0, 1'b0, 1'b0, 8'hFE,  1'b0);
    send(25'h0000001, 1'b0, 1'b0, 1'b0, 8'd3,   1'b0);
    drain();

    // Hold the result with ready low for several cycles
    force_hold = 1'b1;
    send(25'h1800001, 1'b0, 1'b1, 1'b0, 8'd127, 1'b1);
    t = 0;
    while (!o_out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("hold_valid_seen", 64'(o_out_valid), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    force_hold = 1'b0;
    drain();

    for (int n = 0; n < 150; n++) begin
      mode = $urandom_range(0, 5);
      g    = 1'($urandom);
      r    = 1'($urandom);
      s    = 1'($urandom);
      e    = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255));
      case (mode)
        0: m = {1'b1, 24'($urandom)};
        1: m = {2'b01, 23'($urandom)};
        2, 3: begin
          lz = $urandom_range(1, 23);
          m  = 25'($urandom) & ((25'(1) << (23 - lz)) - 25'(1));
          m  = m | (25'(1) << (23 - lz));
        end
        4: m = '0;
        default: begin
          m = '0; g = 1'b0; r = 1'b0; s = 1'b0;
        end
      endcase
      send(m, g, r, s, e, 1'($urandom));
    end
    drain();

    // Reset in the middle of a long left shift
    send(25'h0000001, 1'b0, 1'b0, 1'b0, 8'd100, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("midreset_out_valid", 64'(o_out_valid), 64'd0);
    check("midreset_in_ready", 64'(o_in_ready), 64'd0);
    check("midreset_outputs", 64'(out_vec), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(25'h0000100, 1'b1, 1'b1, 1'b1, 8'd100, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
